// File: rtl/wishbone_master_arbiter.sv
// Two-master to one-port Wishbone arbiter with round-robin grant held for a
// whole cyc cycle, one cycle of grant latency, and a per-transfer watchdog
// that forces termination of strobes the slave never acknowledges.
module wishbone_master_arbiter #(
    parameter int          TIMEOUT_CYCLES = 256,
    parameter logic [31:0] TIMEOUT_DATA   = 32'hDEADBEEF,
    parameter int          CNT_WIDTH      = 16
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_we_i,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_int_o,

    input  logic        m1_we_i,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_int_o,

    output logic        s_we_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    input  logic        s_int_i,

    output logic [1:0]  grant_o,
    output logic        timeout_o,
    input  logic        timeout_clr_i
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] GNT0  = 3'd1;
    localparam logic [2:0] GNT1  = 3'd2;
    localparam logic [2:0] TOUT0 = 3'd3;
    localparam logic [2:0] TOUT1 = 3'd4;

    localparam bit                   WDOG_EN   = (TIMEOUT_CYCLES != 0);
    // Only meaningful when the watchdog is enabled.
    localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [2:0]           state_q, state_d;
    logic                 last_grant_q, last_grant_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 timeout_q, timeout_d;

    // Signals of the master that owns the current GNT/TOUT state.
    logic own_sel;
    logic own_cyc;
    logic own_stb;

    assign own_sel = (state_q == GNT1) || (state_q == TOUT1);
    assign own_cyc = own_sel ? m1_cyc_i : m0_cyc_i;
    assign own_stb = own_sel ? m1_stb_i : m0_stb_i;

    // Next-state, round-robin bookkeeping, watchdog count and sticky flag.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = '0;
        timeout_d    = timeout_q & ~timeout_clr_i;

        case (state_q)
            IDLE: begin
                // On a tie the master that was not served last wins.
                if (m0_cyc_i && (!m1_cyc_i || last_grant_q)) begin
                    state_d      = GNT0;
                    last_grant_d = 1'b0;
                end else if (m1_cyc_i) begin
                    state_d      = GNT1;
                    last_grant_d = 1'b1;
                end
            end
            GNT0, GNT1: begin
                if (!own_cyc) begin
                    state_d = IDLE;
                end else if (WDOG_EN && own_stb && !s_ack_i) begin
                    // An ack in the limit cycle falls through as a normal ack.
                    if (cnt_q == CNT_LIMIT) begin
                        state_d = own_sel ? TOUT1 : TOUT0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            TOUT0, TOUT1: begin
                state_d = own_cyc ? (own_sel ? GNT1 : GNT0) : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Set has priority over a clear seen in the same cycle.
        if ((state_d == TOUT0) || (state_d == TOUT1)) begin
            timeout_d = 1'b1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            timeout_q    <= timeout_d;
        end
    end

    // Per-master ownership vectors; forced idle while reset is held.
    logic [1:0] grant_vec;
    logic [1:0] tout_vec;

    assign grant_vec = rst ? 2'b00 : {state_q == GNT1, state_q == GNT0};
    assign tout_vec  = rst ? 2'b00 : {state_q == TOUT1, state_q == TOUT0};

    logic [1:0]  m_ack;
    logic [31:0] m_dat [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_master_ret
        assign m_ack[gi] = grant_vec[gi] ? s_ack_i : tout_vec[gi];
        assign m_dat[gi] = grant_vec[gi] ? s_dat_i :
                           (tout_vec[gi] ? TIMEOUT_DATA : 32'h0);
    end

    assign m0_ack_o = m_ack[0];
    assign m1_ack_o = m_ack[1];
    assign m0_dat_o = m_dat[0];
    assign m1_dat_o = m_dat[1];

    assign m0_int_o = s_int_i;
    assign m1_int_o = s_int_i;

    // The owner keeps the grant indication through its forced-termination cycle.
    assign grant_o   = grant_vec | tout_vec;
    assign timeout_o = timeout_q;

    // Slave-side mux: the granted master drives the port, otherwise all zero.
    always_comb begin
        s_we_o  = 1'b0;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        if (grant_vec[0]) begin
            s_we_o  = m0_we_i;
            s_cyc_o = m0_cyc_i;
            s_stb_o = m0_stb_i;
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
        end else if (grant_vec[1]) begin
            s_we_o  = m1_we_i;
            s_cyc_o = m1_cyc_i;
            s_stb_o = m1_stb_i;
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
        end
    end

endmodule

// File: tb/tb_wishbone_master_arbiter.sv
// Directed testbench for wishbone_master_arbiter with an 8-cycle watchdog.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_wishbone_master_arbiter;

    logic        clk;
    logic        rst;
    logic        m0_we_i, m0_cyc_i, m0_stb_i;
    logic [31:0] m0_adr_i, m0_dat_i, m0_dat_o;
    logic        m0_ack_o, m0_int_o;
    logic        m1_we_i, m1_cyc_i, m1_stb_i;
    logic [31:0] m1_adr_i, m1_dat_i, m1_dat_o;
    logic        m1_ack_o, m1_int_o;
    logic        s_we_o, s_cyc_o, s_stb_o;
    logic [31:0] s_adr_o, s_dat_o, s_dat_i;
    logic        s_ack_i, s_int_i;
    logic [1:0]  grant_o;
    logic        timeout_o;
    logic        timeout_clr_i;

    int checks;
    int errors;

    wishbone_master_arbiter #(
        .TIMEOUT_CYCLES (8),
        .TIMEOUT_DATA   (32'hDEADBEEF),
        .CNT_WIDTH      (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .m0_we_i       (m0_we_i),
        .m0_cyc_i      (m0_cyc_i),
        .m0_stb_i      (m0_stb_i),
        .m0_adr_i      (m0_adr_i),
        .m0_dat_i      (m0_dat_i),
        .m0_dat_o      (m0_dat_o),
        .m0_ack_o      (m0_ack_o),
        .m0_int_o      (m0_int_o),
        .m1_we_i       (m1_we_i),
        .m1_cyc_i      (m1_cyc_i),
        .m1_stb_i      (m1_stb_i),
        .m1_adr_i      (m1_adr_i),
        .m1_dat_i      (m1_dat_i),
        .m1_dat_o      (m1_dat_o),
        .m1_ack_o      (m1_ack_o),
        .m1_int_o      (m1_int_o),
        .s_we_o        (s_we_o),
        .s_cyc_o       (s_cyc_o),
        .s_stb_o       (s_stb_o),
        .s_adr_o       (s_adr_o),
        .s_dat_o       (s_dat_o),
        .s_dat_i       (s_dat_i),
        .s_ack_i       (s_ack_i),
        .s_int_i       (s_int_i),
        .grant_o       (grant_o),
        .timeout_o     (timeout_o),
        .timeout_clr_i (timeout_clr_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge, where inputs are changed.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        m0_we_i = 0; m0_cyc_i = 0; m0_stb_i = 0; m0_adr_i = 0; m0_dat_i = 0;
        m1_we_i = 0; m1_cyc_i = 0; m1_stb_i = 0; m1_adr_i = 0; m1_dat_i = 0;
        s_dat_i = 0; s_ack_i = 0; s_int_i = 0; timeout_clr_i = 0;
    endtask

    task automatic do_reset();
        next_cycle();
        rst = 1'b1;
        idle_inputs();
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        idle_inputs();

        // Reset state
        next_cycle();
        next_cycle();
        settle();
        check_val("rst_s_cyc", {31'b0, s_cyc_o}, 32'h0);
        check_val("rst_grant", {30'b0, grant_o}, 32'h0);
        check_val("rst_tout", {31'b0, timeout_o}, 32'h0);
        check_val("rst_m0_ack", {31'b0, m0_ack_o}, 32'h0);
        check_val("rst_m0_dat", m0_dat_o, 32'h0);

        // 1. m0 single write
        next_cycle();
        rst = 1'b0;
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1;
        m0_adr_i = 32'h01000004; m0_dat_i = 32'h12345678;
        settle();
        check_val("t1_latency_grant", {30'b0, grant_o}, 32'h0);
        check_val("t1_latency_cyc", {31'b0, s_cyc_o}, 32'h0);
        next_cycle();
        settle();
        check_val("t1_grant", {30'b0, grant_o}, 32'h1);
        check_val("t1_s_adr", s_adr_o, 32'h01000004);
        check_val("t1_s_dat", s_dat_o, 32'h12345678);
        check_val("t1_s_we", {31'b0, s_we_o}, 32'h1);
        next_cycle();
        s_ack_i = 1; s_dat_i = 32'hCAFE0001; s_int_i = 1;
        settle();
        check_val("t1_m0_ack", {31'b0, m0_ack_o}, 32'h1);
        check_val("t1_m0_dat", m0_dat_o, 32'hCAFE0001);
        check_val("t1_m1_ack", {31'b0, m1_ack_o}, 32'h0);
        check_val("t1_m1_dat", m1_dat_o, 32'h0);
        check_val("t1_m1_int", {31'b0, m1_int_o}, 32'h1);
        $display("txn write m0 adr=0x%08h dat=0x%08h", m0_adr_i, m0_dat_i);
        next_cycle();
        idle_inputs();
        next_cycle();
        settle();
        check_val("t1_idle_grant", {30'b0, grant_o}, 32'h0);

        // 2. simultaneous requests after reset: m0 first, one IDLE gap, then m1
        do_reset();
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h00000100;
        m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h00000200;
        next_cycle();
        s_ack_i = 1; s_dat_i = 32'h00000A00;
        settle();
        check_val("t2_grant_m0", {30'b0, grant_o}, 32'h1);
        check_val("t2_s_adr_m0", s_adr_o, 32'h00000100);
        check_val("t2_m1_ack_blocked", {31'b0, m1_ack_o}, 32'h0);
        $display("txn read m0 adr=0x%08h", 32'h00000100);
        next_cycle();
        s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
        next_cycle();
        settle();
        check_val("t2_gap_grant", {30'b0, grant_o}, 32'h0);
        check_val("t2_gap_cyc", {31'b0, s_cyc_o}, 32'h0);
        next_cycle();
        s_ack_i = 1; s_dat_i = 32'h00000B00;
        settle();
        check_val("t2_grant_m1", {30'b0, grant_o}, 32'h2);
        check_val("t2_s_adr_m1", s_adr_o, 32'h00000200);
        check_val("t2_m1_dat", m1_dat_o, 32'h00000B00);
        check_val("t2_m0_ack", {31'b0, m0_ack_o}, 32'h0);
        $display("txn read m1 adr=0x%08h", 32'h00000200);
        next_cycle();
        idle_inputs();
        next_cycle();

        // 3. four back-to-back contended transfers alternate m0, m1, m0, m1
        for (int k = 0; k < 4; k++) begin
            m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h10 + k;
            m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h20 + k;
            next_cycle();
            s_ack_i = 1;
            settle();
            check_val($sformatf("t3_grant_%0d", k), {30'b0, grant_o},
                      (k % 2 == 0) ? 32'h1 : 32'h2);
            $display("txn rr %0d grant=%b", k, grant_o);
            next_cycle();
            s_ack_i = 0;
            if (k % 2 == 0) begin
                m0_cyc_i = 0; m0_stb_i = 0;
            end else begin
                m1_cyc_i = 0; m1_stb_i = 0;
            end
            next_cycle();
        end
        idle_inputs();
        next_cycle();

        // 4. m1 read never acknowledged: forced termination after 8 stalls
        m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h00003000;
        for (int i = 0; i < 8; i++) begin
            next_cycle();
            settle();
            check_val($sformatf("t4_stall_%0d", i), {31'b0, m1_ack_o}, 32'h0);
        end
        next_cycle();
        settle();
        check_val("t4_tout_ack", {31'b0, m1_ack_o}, 32'h1);
        check_val("t4_tout_dat", m1_dat_o, 32'hDEADBEEF);
        check_val("t4_tout_stb", {31'b0, s_stb_o}, 32'h0);
        check_val("t4_tout_cyc", {31'b0, s_cyc_o}, 32'h0);
        check_val("t4_tout_m0_ack", {31'b0, m0_ack_o}, 32'h0);
        $display("txn read m1 adr=0x%08h timed out dat=0x%08h", m1_adr_i, m1_dat_o);
        m1_cyc_i = 0; m1_stb_i = 0;
        next_cycle();
        settle();
        check_val("t4_flag_set", {31'b0, timeout_o}, 32'h1);
        check_val("t4_single_pulse", {31'b0, m1_ack_o}, 32'h0);
        next_cycle();
        settle();
        check_val("t4_flag_sticky", {31'b0, timeout_o}, 32'h1);
        next_cycle();
        timeout_clr_i = 1;
        next_cycle();
        timeout_clr_i = 0;
        settle();
        check_val("t4_flag_cleared", {31'b0, timeout_o}, 32'h0);

        // 5. ack on the 8th stalled cycle is a normal ack
        next_cycle();
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h00004000;
        for (int i = 0; i < 7; i++) begin
            next_cycle();
            settle();
            check_val($sformatf("t5_stall_%0d", i), {31'b0, m0_ack_o}, 32'h0);
        end
        next_cycle();
        s_ack_i = 1; s_dat_i = 32'h5A5A0005;
        settle();
        check_val("t5_ack", {31'b0, m0_ack_o}, 32'h1);
        check_val("t5_dat", m0_dat_o, 32'h5A5A0005);
        $display("txn read m0 adr=0x%08h late ack dat=0x%08h", m0_adr_i, m0_dat_o);
        next_cycle();
        idle_inputs();
        settle();
        check_val("t5_no_extra_ack", {31'b0, m0_ack_o}, 32'h0);
        next_cycle();
        settle();
        check_val("t5_flag_clear", {31'b0, timeout_o}, 32'h0);
        check_val("t5_idle_grant", {30'b0, grant_o}, 32'h0);

        // 6. reset while GNT0 holds stb high, then arbitration resumes
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h00005000;
        next_cycle();
        settle();
        check_val("t6_pre_cyc", {31'b0, s_cyc_o}, 32'h1);
        next_cycle();
        rst = 1;
        next_cycle();
        rst = 0;
        settle();
        check_val("t6_rst_cyc", {31'b0, s_cyc_o}, 32'h0);
        check_val("t6_rst_stb", {31'b0, s_stb_o}, 32'h0);
        check_val("t6_rst_grant", {30'b0, grant_o}, 32'h0);
        next_cycle();
        settle();
        check_val("t6_resume_grant", {30'b0, grant_o}, 32'h1);
        check_val("t6_resume_adr", s_adr_o, 32'h00005000);
        $display("txn m0 re-issued adr=0x%08h after reset", m0_adr_i);
        next_cycle();
        idle_inputs();
        next_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wishbone_master_arbiter.md
Name: wishbone_master_arbiter

Overview:
Two-master to one-port Wishbone arbiter placed in front of the interconnect's single master port, so that two requesters (host interface and DMA engine) can share the slave address space. Arbitration is round-robin and the grant is held for a whole cyc cycle. A per-transfer watchdog ends any strobe that a slave never acknowledges, and sets a sticky flag. The block adds one cycle of grant latency. There is no address decoding; that stays in the interconnect.

Parameters:
TIMEOUT_CYCLES, 256, number of consecutive stalled cycles (stb high, ack low) before forced termination; 0 disables the watchdog
TIMEOUT_DATA, 32'hDEADBEEF, read data returned to the master on a forced termination
CNT_WIDTH, 16, width of the watchdog counter; must hold TIMEOUT_CYCLES-1

Ports:
clk  in  1  system clock, all logic on the rising edge
rst  in  1  synchronous, active-high reset
m0_we_i / m0_cyc_i / m0_stb_i  in  1 each  master 0 control
m0_adr_i  in  32  master 0 address
m0_dat_i  in  32  master 0 write data
m0_dat_o  out  32  master 0 read data
m0_ack_o  out  1  master 0 acknowledge
m0_int_o  out  1  interrupt to master 0
m1_we_i, m1_cyc_i, m1_stb_i, m1_adr_i, m1_dat_i, m1_dat_o, m1_ack_o, m1_int_o  same as above, for master 1
s_we_o / s_cyc_o / s_stb_o  out  1 each  control to the interconnect master port
s_adr_o  out  32  address to the interconnect
s_dat_o  out  32  write data to the interconnect
s_dat_i  in  32  read data from the interconnect
s_ack_i  in  1  acknowledge from the interconnect
s_int_i  in  1  interrupt from the interconnect
grant_o  out  2  one-hot current grant: bit0 = m0, bit1 = m1, 00 = none
timeout_o  out  1  sticky watchdog-fired flag
timeout_clr_i  in  1  clears timeout_o

Behaviour:
- States: IDLE, GNT0, GNT1, TOUT0, TOUT1.
- Registers: state, last_grant (1 bit), cnt (CNT_WIDTH bits), timeout_o.
- Reset (sync): state=IDLE, last_grant=1 (so m0 wins the first tie), cnt=0, timeout_o=0.
- Outputs during and after reset:
  - all s_* outputs 0
  - m*_ack_o 0, m*_dat_o 0, grant_o 00
- IDLE:
  - all s_* outputs 0.
  - Only m0_cyc_i high: go to GNT0.
  - Only m1_cyc_i high: go to GNT1.
  - Both high: grant the master not equal to last_grant.
  - Neither high: stay in IDLE.
  - Grant is visible one cycle after the request (registered).
- GNTx:
  - s_we/cyc/stb/adr/dat_o come combinationally from master x.
  - mx_ack_o = s_ack_i and mx_dat_o = s_dat_i.
  - The other master sees ack_o=0 and dat_o=0.
  - grant_o is one-hot x. On entry, last_grant is set to x.
- Leaving GNTx:
  - mx_cyc_i low: go to IDLE, which is always at least one IDLE cycle between grants; cnt=0.
  - The other master's requests are ignored while x holds cyc (no preemption).
- Watchdog (only when TIMEOUT_CYCLES != 0):
  - In GNTx with mx_stb_i=1 and s_ack_i=0: cnt increments.
  - Any other condition: cnt=0.
  - If cnt==TIMEOUT_CYCLES-1 and the stall persists, the next state is TOUTx.
- TOUTx (lasts exactly 1 cycle):
  - s_cyc_o=0 and s_stb_o=0, which aborts the slave cycle.
  - mx_ack_o=1 and mx_dat_o=TIMEOUT_DATA.
  - timeout_o set to 1; cnt=0.
  - Next state is GNTx if mx_cyc_i=1, else IDLE.
- timeout_o:
  - Cleared by timeout_clr_i in the cycle after it is seen.
  - If a set and a clear happen in the same cycle, the set wins.
- An s_ack_i arriving in the same cycle that cnt reaches its limit counts as a normal ack: no timeout.
- Interrupts: m0_int_o = m1_int_o = s_int_i, broadcast and combinational.
- Reset mid-transfer: state goes to IDLE on the next edge and the s_* outputs drop to 0. The master must re-issue its transfer.
- Burst: while a master holds cyc and toggles stb, it keeps the grant across several acks.

Test Plan:
1. Reset, then m0 alone writes 0x12345678 to adr 0x01000004 → s_adr_o=0x01000004 one cycle after cyc; slave ack returns on m0_ack_o; grant_o=01; m1_ack_o stays 0.
2. m0 and m1 raise cyc in the same cycle after reset → m0 is granted first (grant_o=01); after m0 drops cyc there is 1 IDLE cycle, then grant_o=10 for m1.
3. Repeated simultaneous requests, 4 transfers → grant sequence m0, m1, m0, m1.
4. TIMEOUT_CYCLES=8, slave never acks m1's read → m1_ack_o pulses once exactly after 8 stalled cycles, with m1_dat_o=0xDEADBEEF; s_stb_o=0 in that cycle; timeout_o=1 until timeout_clr_i pulses.
5. Slave ack arrives on the 8th stalled cycle → normal ack with the slave data; timeout_o stays 0.
6. rst asserted while GNT0 has stb high → next cycle s_cyc_o=0, s_stb_o=0, grant_o=00, then normal arbitration resumes.
